// File: rtl/fetch_decode_stage_pkg.sv
// Shared widths, opcode constants and the registered decode slot for fetch_decode_stage.
package fetch_decode_stage_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [1:0] ALU_ADDR   = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic branch;
    logic uncond_branch;
  } ctrl_t;

  // One pipeline slot; an all-zero slot is the bubble.
  typedef struct packed {
    logic [WORD-1:0] rd1;
    logic [WORD-1:0] rd2;
    logic [WORD-1:0] imm;
    logic [WORD-1:0] pc;
    logic [4:0]      rd;
    ctrl_t           ctrl;
    logic [1:0]      alu_op;
    logic            valid;
    logic            illegal;
  } slot_t;

endpackage

// File: rtl/fetch_decode_stage_reg_file.sv
// 31 x 64-bit register file (X31 reads as zero), two async reads, one sync write.
// Define DECODE_WB_BYPASS_EN to forward a same-cycle write onto the read ports.
module reg_file
  import fetch_decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  output logic [WORD-1:0] rd1_o,
  output logic [WORD-1:0] rd2_o,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [WORD-1:0] wd_i
);

  logic [WORD-1:0] regs_q [0:30];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 31; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != XZR)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  logic [WORD-1:0] arr1, arr2;
  assign arr1 = (ra1_i == XZR) ? '0 : regs_q[ra1_i];
  assign arr2 = (ra2_i == XZR) ? '0 : regs_q[ra2_i];

`ifdef DECODE_WB_BYPASS_EN
  assign rd1_o = (we_i && (wa_i == ra1_i) && (ra1_i != XZR)) ? wd_i : arr1;
  assign rd2_o = (we_i && (wa_i == ra2_i) && (ra2_i != XZR)) ? wd_i : arr2;
`else
  assign rd1_o = arr1;
  assign rd2_o = arr2;
`endif

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode pipeline register: decodes one LEGv8 instruction, reads operands, registers the slot.
// Writeback bypass onto the operand reads is enabled with DECODE_WB_BYPASS_EN.
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic [WORD-1:0]      pc_in,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [WORD-1:0]      wb_data,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2,
  output logic [WORD-1:0]      sign_imm,
  output logic [WORD-1:0]      pc_out,
  output logic [4:0]           rd,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 alu_src,
  output logic                 branch,
  output logic                 uncond_branch,
  output logic [1:0]           alu_op,
  output logic                 out_valid,
  output logic                 illegal
);

  logic [10:0]     opcode;
  logic            is_r, is_ld, is_st, is_cbz, is_b;
  logic [4:0]      ra2;
  logic [WORD-1:0] rf_rd1, rf_rd2;
  slot_t           slot_d, slot_q;

  assign opcode = instruction[31:21];
  assign is_r   = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_ORR};
  assign is_ld  = (opcode == OP_LDUR);
  assign is_st  = (opcode == OP_STUR);
  assign is_cbz = (instruction[31:24] == OP_CBZ_PFX);
  assign is_b   = (instruction[31:26] == OP_B_PFX);

  // STUR and CBZ read the Rt field on port 2 (store data / compare value).
  assign ra2 = (is_st || is_cbz) ? instruction[4:0] : instruction[20:16];

  reg_file u_reg_file (
    .clk   (clk),
    .reset (reset),
    .ra1_i (instruction[9:5]),
    .ra2_i (ra2),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
    .we_i  (wb_en),
    .wa_i  (wb_addr),
    .wd_i  (wb_data)
  );

  always_comb begin
    slot_d       = '0;
    slot_d.valid = 1'b1;
    slot_d.pc    = pc_in;
    slot_d.rd    = instruction[4:0];
    slot_d.rd1   = rf_rd1;
    slot_d.rd2   = rf_rd2;
    if (is_r) begin
      slot_d.ctrl.reg_write = 1'b1;
      slot_d.alu_op         = ALU_RTYPE;
    end else if (is_ld) begin
      slot_d.ctrl.reg_write  = 1'b1;
      slot_d.ctrl.mem_read   = 1'b1;
      slot_d.ctrl.mem_to_reg = 1'b1;
      slot_d.ctrl.alu_src    = 1'b1;
      slot_d.alu_op          = ALU_ADDR;
      slot_d.imm             = {{(WORD-9){instruction[20]}}, instruction[20:12]};
    end else if (is_st) begin
      slot_d.ctrl.mem_write = 1'b1;
      slot_d.ctrl.alu_src   = 1'b1;
      slot_d.alu_op         = ALU_ADDR;
      slot_d.imm            = {{(WORD-9){instruction[20]}}, instruction[20:12]};
    end else if (is_cbz) begin
      slot_d.ctrl.branch = 1'b1;
      slot_d.alu_op      = ALU_PASS_B;
      slot_d.imm         = {{(WORD-19){instruction[23]}}, instruction[23:5]};
    end else if (is_b) begin
      slot_d.ctrl.uncond_branch = 1'b1;
      slot_d.imm                = {{(WORD-26){instruction[25]}}, instruction[25:0]};
    end else begin
      slot_d.illegal = 1'b1;
    end
  end

  // Flush beats stall; a bubble is the all-zero slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
    end else if (flush) begin
      slot_q <= '0;
    end else if (!stall) begin
      slot_q <= in_valid ? slot_d : '0;
    end
  end

  assign read_data1    = slot_q.rd1;
  assign read_data2    = slot_q.rd2;
  assign sign_imm      = slot_q.imm;
  assign pc_out        = slot_q.pc;
  assign rd            = slot_q.rd;
  assign reg_write     = slot_q.ctrl.reg_write;
  assign mem_read      = slot_q.ctrl.mem_read;
  assign mem_write     = slot_q.ctrl.mem_write;
  assign mem_to_reg    = slot_q.ctrl.mem_to_reg;
  assign alu_src       = slot_q.ctrl.alu_src;
  assign branch        = slot_q.ctrl.branch;
  assign uncond_branch = slot_q.ctrl.uncond_branch;
  assign alu_op        = slot_q.alu_op;
  assign out_valid     = slot_q.valid;
  assign illegal       = slot_q.illegal;

endmodule
